pe_psum_accumulator: RTL and testbench
======================================

Name: pe_psum_accumulator

Overview:
Downstream stage of the PE multiply-accumulate unit. Consumes the PE's 31-bit signed partial sums, one per beat, over a kernel window delimited by a last flag. At window end it applies optional ReLU, round-half-up right shift and signed saturation to produce one 16-bit activation. The result is held in a one-entry output register with valid/ready handshakes on both sides.

Parameters:
PSUM_W, 31, width of the signed partial-sum input; matches the PE result width.
OUT_W, 16, width of the signed output activation; matches the PE operand width.
ACC_W, 40, internal accumulator width; must be at least PSUM_W + clog2(MAX_BEATS) + 1.
MAX_BEATS, 256, maximum number of beats per window.
SHIFT, 0, arithmetic right shift applied at window end; range 0..ACC_W-OUT_W.
RELU_EN, 1, 1 clamps negative window sums to 0 before shift and saturation.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  partial-sum beat valid
in_ready  out  1  stage can accept a beat
in_psum  in  PSUM_W  signed partial sum from the PE
in_last  in  1  beat closes the current window
out_valid  out  1  output register holds a result
out_ready  in  1  consumer accepts the result
out_data  out  OUT_W  signed activation
out_sat  out  1  result was clipped by saturation
out_beats  out  9  number of beats in the window, 1..256
len_err  out  1  sticky: window exceeded MAX_BEATS

Behaviour:
- Reset (async assert, sync release): acc=0, beat_cnt=0, state=IDLE. out_valid, out_data, out_sat, out_beats and len_err are all 0.
- Clock and reset naming are fixed: one clock, clk; reset rst_n, asynchronous, active-low.
- A beat is accepted when in_valid && in_ready. A result is taken when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This rule holds in every state, including mid-window, so the output register is never overwritten.
- FSM states:
  - IDLE: no beats held. An accepted beat loads acc = sext(in_psum) and sets beat_cnt=1. Next state is ACCUM, or stays IDLE if in_last is set on that beat.
  - ACCUM: each accepted beat does acc += sext(in_psum) and beat_cnt += 1. An accepted beat with in_last returns to IDLE.
- Window close, computed combinationally on the sum that includes the last beat and registered at that edge:
  - v = (RELU_EN && sum<0) ? 0 : sum.
  - If SHIFT>0: v = (v + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, ties round toward +inf.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat=1 if clipping occurred.
  - The ReLU clamp alone does not set out_sat.
- Latency: out_valid rises the cycle after the last beat is accepted. out_beats holds the window's beat count, including the last beat.
- Single-beat window: in_last on the first beat is legal; out_beats=1.
- Simultaneous events: in the same cycle the output may be taken while a new last beat is accepted. The register then reloads and out_valid stays 1.
- The output register holds out_data, out_sat and out_beats stable while out_valid && !out_ready.
- Length error: an accepted beat with beat_cnt==MAX_BEATS and !in_last sets len_err, which stays set until reset.
  - On that error, beat_cnt saturates at MAX_BEATS and acc keeps adding; the window's data is then unspecified.
- No overflow is possible inside acc while beat_cnt<=MAX_BEATS.
- Mid-operation reset: any partial window and any pending output are discarded; no result is emitted.
- in_psum and in_last are sampled only on accepted beats; their values on other cycles are ignored.

Decomposition:
- Shared package cnn_pkg: PSUM_W=31, OUT_W=16 and the psum/activation widths, shared with the PE and its neighbours. Also a clog2-based constant for the beat-counter width.
- One sub-module, psum_requant: purely combinational ReLU, round, shift and saturate. Inputs are the ACC_W sum; outputs are OUT_W data and the sat flag. It is reused by later pooling stages.
- The top level owns the FSM, accumulator, beat counter and output register.

Test Plan:
1. Defaults, single beat in_psum=21 (0x15, the PE's 2*8+5), in_last=1, out_ready=1 -> next cycle out_valid=1, out_data=0x0015, out_sat=0, out_beats=1.
2. Three beats of 0x3FFF0001 (the 0x7FFF*0x7FFF product), last on the third -> out_data=0x7FFF, out_sat=1, out_beats=3.
3. Beats -1 (0x7FFFFFFF as 31-bit) then -3 with last:
   - RELU_EN=1 -> out_data=0x0000, out_sat=0.
   - RELU_EN=0 -> out_data=0xFFFC.
4. SHIFT=4, beats 16 and 8 with last (sum 24) -> out_data=0x0002 (1.5 rounds up). A sum of 23 -> 0x0001.
5. Backpressure: out_ready=0 with a result pending -> in_ready=0 and out_data stable for 5 cycles. Raise out_ready while a new last beat of 7 is offered -> same-cycle handoff, then out_data=0x0007 with out_valid continuously 1.
6. Send 257 beats without last -> len_err=1 on the cycle after the 257th beat. Assert rst_n=0 mid-window -> all outputs 0 immediately. After release, a single beat of 5 with last -> out_data=0x0005, out_beats=1.

Source files
------------

// File: rtl/cnn_pkg.sv
// Widths and types shared by the PE datapath and its downstream accumulation,
// requantisation and pooling stages.
package cnn_pkg;

   localparam int PSUM_W     = 31;
   localparam int OUT_W      = 16;
   localparam int MAX_BEATS  = 256;
   localparam int BEAT_CNT_W = $clog2(MAX_BEATS + 1);

   typedef logic signed [PSUM_W-1:0] psum_t;
   typedef logic signed [OUT_W-1:0]  act_t;

   typedef enum logic {
      ACC_IDLE,
      ACC_ACCUM
   } acc_state_e;

endpackage

// File: rtl/psum_requant.sv
// Combinational requantiser: optional ReLU, round-half-up arithmetic shift,
// then signed saturation of a wide accumulator value down to an activation.
module psum_requant #(
   parameter int ACC_W   = 40,
   parameter int OUT_W   = 16,
   parameter int SHIFT   = 0,
   parameter int RELU_EN = 1
) (
   input  logic signed [ACC_W-1:0] sum_i,
   output logic signed [OUT_W-1:0] data_o,
   output logic                    sat_o
);

   localparam int SH_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [ACC_W:0] ONE     = {{ACC_W{1'b0}}, 1'b1};
   localparam logic signed [ACC_W:0] RND     = (SHIFT > 0) ? (ONE <<< SH_M1) : '0;
   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - ONE;

   logic signed [ACC_W-1:0] relu_v;
   logic signed [ACC_W:0]   v_ext;
   logic signed [ACC_W:0]   rounded;

   // One guard bit keeps the rounding add from wrapping near the top of the range.
   always_comb begin
      relu_v  = ((RELU_EN != 0) && sum_i[ACC_W-1]) ? '0 : sum_i;
      v_ext   = {relu_v[ACC_W-1], relu_v};
      rounded = (v_ext + RND) >>> SHIFT;
      sat_o   = 1'b0;
      data_o  = rounded[OUT_W-1:0];
      if (rounded > SAT_MAX) begin
         data_o = SAT_MAX[OUT_W-1:0];
         sat_o  = 1'b1;
      end else if (rounded < SAT_MIN) begin
         data_o = SAT_MIN[OUT_W-1:0];
         sat_o  = 1'b1;
      end
   end

endmodule

// File: rtl/pe_psum_accumulator.sv
// Accumulates PE partial sums over a last-delimited window and emits one
// requantised activation through a one-entry valid/ready output register.
module pe_psum_accumulator #(
   parameter int PSUM_W    = cnn_pkg::PSUM_W,
   parameter int OUT_W     = cnn_pkg::OUT_W,
   parameter int ACC_W     = 40,
   parameter int MAX_BEATS = cnn_pkg::MAX_BEATS,
   parameter int SHIFT     = 0,
   parameter int RELU_EN   = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic signed [PSUM_W-1:0]             in_psum,
   input  logic                                 in_last,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic signed [OUT_W-1:0]              out_data,
   output logic                                 out_sat,
   output logic [$clog2(MAX_BEATS+1)-1:0]       out_beats,
   output logic                                 len_err
);

   import cnn_pkg::*;

   localparam int CNT_W = $clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   acc_state_e              state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0] out_data_q, out_data_d;
   logic                    out_sat_q, out_sat_d;
   logic [CNT_W-1:0]        out_beats_q, out_beats_d;
   logic                    len_err_q, len_err_d;

   logic                    beat_acc;
   logic signed [ACC_W-1:0] psum_ext;
   logic signed [ACC_W-1:0] sum;
   logic [CNT_W-1:0]        cnt_inc;
   logic signed [OUT_W-1:0] rq_data;
   logic                    rq_sat;

   // A beat is refused only while an untaken result would be overwritten.
   assign in_ready = !out_valid_q || out_ready;
   assign beat_acc = in_valid && in_ready;
   assign psum_ext = {{(ACC_W-PSUM_W){in_psum[PSUM_W-1]}}, in_psum};
   assign sum      = (state_q == ACC_IDLE) ? psum_ext : acc_q + psum_ext;
   assign cnt_inc  = (state_q == ACC_IDLE) ? CNT_ONE :
                     (cnt_q == CNT_MAX)    ? cnt_q   : cnt_q + CNT_ONE;

   psum_requant #(
      .ACC_W   (ACC_W),
      .OUT_W   (OUT_W),
      .SHIFT   (SHIFT),
      .RELU_EN (RELU_EN)
   ) u_requant (
      .sum_i  (sum),
      .data_o (rq_data),
      .sat_o  (rq_sat)
   );

   // NOTE: every _d gets its hold value first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      out_beats_d = out_beats_q;
      len_err_d   = len_err_q;

      if (out_valid_q && out_ready)
         out_valid_d = 1'b0;

      if (beat_acc) begin
         acc_d = sum;
         cnt_d = cnt_inc;
         if ((cnt_q == CNT_MAX) && !in_last)
            len_err_d = 1'b1;
         if (in_last) begin
            state_d     = ACC_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = rq_data;
            out_sat_d   = rq_sat;
            out_beats_d = cnt_inc;
         end else begin
            state_d = ACC_ACCUM;
         end
      end
   end

   // NOTE: state updates use non-blocking assignments so all flops sample together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACC_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_beats_q <= '0;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         out_beats_q <= out_beats_d;
         len_err_q   <= len_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign out_beats = out_beats_q;
   assign len_err   = len_err_q;

endmodule

// File: tb/tb_pe_psum_accumulator.sv
// Self-checking bench: three accumulator instances (default, ReLU off, SHIFT=4)
// share one stimulus stream and are checked against an arithmetic window model.
module tb_pe_psum_accumulator;

   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic [30:0] in_psum = '0;
   logic in_last = 1'b0;
   logic out_ready = 1'b1;

   logic        in_ready_w  [NI];
   logic        out_valid_w [NI];
   logic [15:0] out_data_w  [NI];
   logic        out_sat_w   [NI];
   logic [8:0]  out_beats_w [NI];
   logic        len_err_w   [NI];

   int relu_p  [NI] = '{1, 0, 1};
   int shift_p [NI] = '{0, 0, 4};

   int checks = 0;
   int failures = 0;

   logic [30:0] win_q[$];
   logic [15:0] exp_data [NI];
   logic        exp_sat  [NI];
   int          exp_beats;

   always #5 clk = ~clk;

   pe_psum_accumulator #(.RELU_EN(1), .SHIFT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .in_psum(in_psum), .in_last(in_last), .out_valid(out_valid_w[0]),
      .out_ready(out_ready), .out_data(out_data_w[0]), .out_sat(out_sat_w[0]),
      .out_beats(out_beats_w[0]), .len_err(len_err_w[0]));

   pe_psum_accumulator #(.RELU_EN(0), .SHIFT(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .in_psum(in_psum), .in_last(in_last), .out_valid(out_valid_w[1]),
      .out_ready(out_ready), .out_data(out_data_w[1]), .out_sat(out_sat_w[1]),
      .out_beats(out_beats_w[1]), .len_err(len_err_w[1]));

   pe_psum_accumulator #(.RELU_EN(1), .SHIFT(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
      .in_psum(in_psum), .in_last(in_last), .out_valid(out_valid_w[2]),
      .out_ready(out_ready), .out_data(out_data_w[2]), .out_sat(out_sat_w[2]),
      .out_beats(out_beats_w[2]), .len_err(len_err_w[2]));

   // Window result from the arithmetic definition: clamp, divide by 2^shift
   // rounding halves upward, then clip to the 16-bit signed range.
   function automatic void model(input longint sum, input int relu, input int shift,
                                 output logic [15:0] d, output logic s);
      longint v;
      v = (relu != 0 && sum < 0) ? 64'sd0 : sum;
      if (shift > 0) begin
         longint p;
         p = longint'(1) << shift;
         v = v + p / 2;
         v = (v >= 0) ? v / p : -((-v + p - 1) / p);
      end
      s = 1'b0;
      if (v > 32767) begin
         v = 32767; s = 1'b1;
      end else if (v < -32768) begin
         v = -32768; s = 1'b1;
      end
      d = v[15:0];
   endfunction

   // Drives win_q as one window (last on the final beat) and fills exp_*.
   task automatic drive_window(input bit gaps);
      longint sum = 0;
      for (int i = 0; i < win_q.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_psum  = 31'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_psum  = win_q[i];
         in_last  = (i == win_q.size() - 1);
         sum += longint'($signed(win_q[i]));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int k = 0; k < NI; k++) model(sum, relu_p[k], shift_p[k], exp_data[k], exp_sat[k]);
      exp_beats = win_q.size();
   endtask

   task automatic test_reset();
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (out_valid_w[k] !== 1'b0 || out_data_w[k] !== 16'h0 || out_sat_w[k] !== 1'b0 ||
             out_beats_w[k] !== 9'd0 || len_err_w[k] !== 1'b0 || in_ready_w[k] !== 1'b1) begin
            failures++;
            $display("FAIL reset[%0d]: valid=%b data=%h sat=%b beats=%0d err=%b rdy=%b, want 0/0/0/0/0/1",
                     k, out_valid_w[k], out_data_w[k], out_sat_w[k], out_beats_w[k], len_err_w[k], in_ready_w[k]);
         end
      end
   endtask

   task automatic test_directed(input string name, input logic [30:0] b0, input logic [30:0] b1,
                                input logic [30:0] b2, input int n);
      win_q = {};
      if (n > 0) win_q.push_back(b0);
      if (n > 1) win_q.push_back(b1);
      if (n > 2) win_q.push_back(b2);
      drive_window(1'b0);
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (out_valid_w[k] !== 1'b1 || out_data_w[k] !== exp_data[k] ||
             out_sat_w[k] !== exp_sat[k] || out_beats_w[k] !== 9'(exp_beats)) begin
            failures++;
            $display("FAIL %s[%0d]: valid=%b data=%h sat=%b beats=%0d, want 1 %h %b %0d",
                     name, k, out_valid_w[k], out_data_w[k], out_sat_w[k], out_beats_w[k],
                     exp_data[k], exp_sat[k], exp_beats);
         end
      end
   endtask

   task automatic test_random(input int n_windows);
      for (int w = 0; w < n_windows; w++) begin
         int len = $urandom_range(1, 6);
         win_q = {};
         for (int i = 0; i < len; i++) begin
            int mode = $urandom_range(0, 2);
            int v = (mode == 0) ? $urandom_range(0, 2000) - 1000 :
                    (mode == 1) ? $urandom_range(0, 2 * 1048576) - 1048576 : int'($urandom);
            win_q.push_back(v[30:0]);
         end
         drive_window(1'b1);
         for (int k = 0; k < NI; k++) begin
            checks++;
            if (out_valid_w[k] !== 1'b1 || out_data_w[k] !== exp_data[k] ||
                out_sat_w[k] !== exp_sat[k] || out_beats_w[k] !== 9'(exp_beats)) begin
               failures++;
               $display("FAIL random w%0d[%0d]: valid=%b data=%h sat=%b beats=%0d, want 1 %h %b %0d",
                        w, k, out_valid_w[k], out_data_w[k], out_sat_w[k], out_beats_w[k],
                        exp_data[k], exp_sat[k], exp_beats);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] held [NI];
      win_q = {31'd100};
      drive_window(1'b0);
      out_ready = 1'b0;
      for (int k = 0; k < NI; k++) held[k] = exp_data[k];
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < NI; k++) begin
            checks++;
            if (in_ready_w[k] !== 1'b0 || out_valid_w[k] !== 1'b1 || out_data_w[k] !== held[k]) begin
               failures++;
               $display("FAIL hold c%0d[%0d]: rdy=%b valid=%b data=%h, want 0 1 %h",
                        c, k, in_ready_w[k], out_valid_w[k], out_data_w[k], held[k]);
            end
         end
      end
      in_valid = 1'b1;
      in_psum  = 31'd7;
      in_last  = 1'b1;
      #1 out_ready = 1'b1;
      #1;
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (in_ready_w[k] !== 1'b1) begin
            failures++;
            $display("FAIL handoff_ready[%0d]: rdy=%b, want 1", k, in_ready_w[k]);
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int k = 0; k < NI; k++) begin
         logic [15:0] d;
         logic s;
         model(64'sd7, relu_p[k], shift_p[k], d, s);
         checks++;
         if (out_valid_w[k] !== 1'b1 || out_data_w[k] !== d || out_sat_w[k] !== s ||
             out_beats_w[k] !== 9'd1) begin
            failures++;
            $display("FAIL handoff[%0d]: valid=%b data=%h sat=%b beats=%0d, want 1 %h %b 1",
                     k, out_valid_w[k], out_data_w[k], out_sat_w[k], out_beats_w[k], d, s);
         end
      end
   endtask

   task automatic test_len_err_and_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 259; i++) begin
         in_valid = 1'b1;
         in_psum  = 31'($urandom_range(0, 1000));
         in_last  = 1'b0;
         @(posedge clk); #1;
         if (i == 255 || i == 256) begin
            for (int k = 0; k < NI; k++) begin
               checks++;
               if (len_err_w[k] !== (i == 256)) begin
                  failures++;
                  $display("FAIL len_err beat%0d[%0d]: err=%b, want %b", i + 1, k, len_err_w[k], i == 256);
               end
            end
         end
      end
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (out_valid_w[k] !== 1'b0 || out_data_w[k] !== 16'h0 || out_sat_w[k] !== 1'b0 ||
             out_beats_w[k] !== 9'd0 || len_err_w[k] !== 1'b0) begin
            failures++;
            $display("FAIL midreset[%0d]: valid=%b data=%h sat=%b beats=%0d err=%b, want all 0",
                     k, out_valid_w[k], out_data_w[k], out_sat_w[k], out_beats_w[k], len_err_w[k]);
         end
      end
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (out_valid_w[k] !== 1'b0) begin
            failures++;
            $display("FAIL postreset_idle[%0d]: valid=%b, want 0", k, out_valid_w[k]);
         end
      end
      test_directed("after_reset_5", 31'd5, 31'd0, 31'd0, 1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_directed("single_21", 31'd21, 31'd0, 31'd0, 1);
      test_directed("sat_3beats", 31'h3FFF0001, 31'h3FFF0001, 31'h3FFF0001, 3);
      test_directed("neg_m1_m3", 31'h7FFFFFFF, 31'h7FFFFFFD, 31'd0, 2);
      test_directed("round_24", 31'd16, 31'd8, 31'd0, 2);
      test_directed("round_23", 31'd15, 31'd8, 31'd0, 2);
      test_directed("neg_sat", 31'h40000000, 31'h40000000, 31'd0, 2);
      test_random(40);
      test_backpressure();
      test_len_err_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
